// File: rtl/mem_write_checker.sv
// Self-checking monitor for the core's data-memory write port. Each committed
// store is compared against an ordered table of expected stores, and the result is reported as pass, mismatch, timeout or extra store.
module mem_write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1),
    localparam int IDX_W      = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int MC_W       = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [MC_W-1:0]   num_exp,
    input  logic              ign_en,
    input  logic [ADDR_W-1:0] ign_addr,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [MC_W-1:0]   match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  cyc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [MC_W-1:0]  NUM_MAX = MC_W'(NUM_EXP);

    state_t            state_q, state_d;
    logic [MC_W-1:0]   num_q, num_d;
    logic              ign_en_q, ign_en_d;
    logic [ADDR_W-1:0] ign_addr_q, ign_addr_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [1:0]        fc_q, fc_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [ADDR_W-1:0] exp_addr_q [NUM_EXP];
    logic [DATA_W-1:0] exp_data_q [NUM_EXP];

    logic              skip;
    logic              hit;
    logic [MC_W-1:0]   mc_inc;
    logic [MC_W-1:0]   num_clamped;

    // Table is deliberately left out of reset so a bench can re-arm without reloading.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && tbl_we && int'(tbl_idx) < NUM_EXP) begin
            exp_addr_q[tbl_idx] <= tbl_addr;
            exp_data_q[tbl_idx] <= tbl_data;
        end
    end

    always_comb begin
        skip   = ign_en_q && (data_adr == ign_addr_q);
        hit    = (data_adr == exp_addr_q[mc_q[IDX_W-1:0]]) &&
                 (write_data == exp_data_q[mc_q[IDX_W-1:0]]);
        mc_inc = mc_q + 1'b1;
        if (num_exp == '0) begin
            num_clamped = MC_W'(1);
        end else if (num_exp > NUM_MAX) begin
            num_clamped = NUM_MAX;
        end else begin
            num_clamped = num_exp;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        ign_en_d   = ign_en_q;
        ign_addr_d = ign_addr_q;
        mc_d       = mc_q;
        cyc_d      = cyc_q;
        fc_d       = fc_q;
        fa_d       = fa_q;
        fd_d       = fd_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_clamped;
                    ign_en_d   = ign_en;
                    ign_addr_d = ign_addr;
                    mc_d       = '0;
                    cyc_d      = '0;
                    fc_d       = 2'd0;
                    fa_d       = '0;
                    fd_d       = '0;
                    state_d    = S_ARMED;
                end
            end
            S_ARMED: begin
                cyc_d = (cyc_q == TO_MAX) ? cyc_q : cyc_q + 1'b1;
                if (mem_write && !skip) begin
                    if (hit) begin
                        mc_d = mc_inc;
                        if (mc_inc == num_q) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        fa_d    = data_adr;
                        fd_d    = write_data;
                        fc_d    = 2'd1;
                        state_d = S_FAIL;
                    end
                end
                // A store decided on the final cycle takes priority over the timeout.
                if (state_d == S_ARMED && cyc_d == TO_MAX) begin
                    fc_d    = 2'd2;
                    state_d = S_TIMEOUT;
                end
            end
            S_PASS: begin
                if (mem_write && !skip) begin
                    fa_d    = data_adr;
                    fd_d    = write_data;
                    fc_d    = 2'd3;
                    state_d = S_FAIL;
                end
            end
            default: begin
            end
        endcase

        done_d = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        pass_d = (state_d == S_PASS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            ign_en_q   <= 1'b0;
            ign_addr_q <= '0;
            mc_q       <= '0;
            cyc_q      <= '0;
            fc_q       <= 2'd0;
            fa_q       <= '0;
            fd_q       <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            ign_en_q   <= ign_en_d;
            ign_addr_q <= ign_addr_d;
            mc_q       <= mc_d;
            cyc_q      <= cyc_d;
            fc_q       <= fc_d;
            fa_q       <= fa_d;
            fd_q       <= fd_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fc_q;
    assign match_cnt = mc_q;
    assign fail_addr = fa_q;
    assign fail_data = fd_q;
    assign cyc_cnt   = cyc_q;

endmodule
